sc_level_sequencer: RTL and testbench
=====================================

// Module: sc_level_sequencer
// PURPOSE
//  Game-flow scheduler for RoadFighter. Sequences the road/obstacle shift-register bank:
//  - issues load, scroll and new-row commands;
//  - counts rows to detect end of level;
//  - raises speed per level;
//  - freezes on collision.
//  Drives the FinishedLevel_InLow input of the player FSM and the road datapath.
// PARAMETERS
//  DATAWIDTH_BUS   8            road row width (lanes)
//  PRESC_WIDTH     24           prescaler/period register width
//  TICK_BASE       5_000_000    level-0 scroll period, clocks
//  TICK_STEP       500_000      period decrement per completed level
//  TICK_MIN        1_000_000    period floor
//  ROWS_PER_LEVEL  64           scrolls per level
//  LEVEL_WIDTH     3            level counter width, saturates at 2^LEVEL_WIDTH-1
//  LFSR_SEED       8'hA5        obstacle generator seed, must be non-zero
// PORTS
//  SC_LEVEL_SEQUENCER_CLOCK_50          in   1   system clock
//  SC_LEVEL_SEQUENCER_RESET_InLow       in   1   one clock; reset is asynchronous and active-low
//  SC_LEVEL_SEQUENCER_Start_InLow       in   1   start/restart button, debounced
//  SC_LEVEL_SEQUENCER_Lost_InLow        in   1   collision from player FSM, 0 = lost
//  SC_LEVEL_SEQUENCER_Scroll_Out        out  1   1-cycle pulse: shift road bank one row down
//  SC_LEVEL_SEQUENCER_LoadRoad_OutLow   out  1   0 = parallel-load RoadData into bank
//  SC_LEVEL_SEQUENCER_RoadData_Out      out  8   new top row (valid with Scroll or Load)
//  SC_LEVEL_SEQUENCER_FinishedLevel_OutLow out 1 1-cycle low pulse at level end
//  SC_LEVEL_SEQUENCER_Level_Out         out  LW  current level
// BEHAVIOUR
//  All outputs are registered.
//  Reset values:
//  - Scroll 0, LoadRoad 0, RoadData 0, FinishedLevel 1, Level 0.
//  - Period = TICK_BASE, prescaler 0, row 0, LFSR = seed, state LOAD.
//  States:
//  - LOAD: 1 cycle; LoadRoad=0, RoadData=0 (clear road) -> WAIT_START.
//  - WAIT_START: prescaler held at 0; Start_InLow==0 -> RUN.
//    A held Start re-enters RUN directly.
//  - RUN: prescaler counts 0..period-1. At terminal count:
//    - prescaler returns to 0;
//    - LFSR steps;
//    - next cycle Scroll=1, RoadData = lfsr[7] ? (8'b1<<lfsr[2:0]) : 0;
//    - row counter increments.
//    - The scroll completing row ROWS_PER_LEVEL-1 -> LEVEL_DONE.
//  - Lost_InLow==0 in RUN -> LOST. Lost has priority over a coincident terminal count:
//    no scroll, no LFSR step.
//  - LEVEL_DONE: 1 cycle; FinishedLevel=0.
//    - Level+1, saturating at max.
//    - Period = max(period-TICK_STEP, TICK_MIN); subtraction must not underflow.
//    - Row=0 -> LOAD.
//  - LOST: everything frozen; Start_InLow==0 -> LOAD with Level=0, period=TICK_BASE.
//    LFSR is not reseeded.
//  Scroll and FinishedLevel are never asserted in the same cycle.
//  Scroll is 0 outside RUN.
//  Reset mid-operation forces reset values asynchronously; no partial pulse after release.
//  Unused state encodings -> LOAD.
// CONFIGURATION
//  SC_LEVEL_SEQUENCER_PAUSE_EN defined:
//  - adds input SC_LEVEL_SEQUENCER_Pause_InLow.
//  - In RUN with Pause low: prescaler and row counter hold, no Scroll. Lost is still honoured.
//  - Release resumes from the held count.
//  Undefined: port absent, behaviour as above.
// STRUCTURE
//  Shared package sc_roadfighter_pkg:
//  - state encodings;
//  - DATAWIDTH_BUS;
//  - LFSR_SEED;
//  - lane-mask constants used by the player FSM and road bank.
//  Sub-module sc_obstacle_lfsr:
//  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1;
//  - ports clk, rst_n, step_en, q[7:0].
// TESTING (TICK_BASE=4, TICK_STEP=1, TICK_MIN=2, ROWS_PER_LEVEL=3)
//  - Release reset -> 1 cycle LoadRoad=0, RoadData=0, then WAIT_START. Scroll stays 0 for 20 cycles.
//  - Start low 1 cycle -> Scroll pulses every 4 cycles. RoadData matches reference LFSR from 0xA5.
//  - 3 scrolls -> FinishedLevel low exactly 1 cycle, Level=1, LOAD pulse. Next run scroll interval 3.
//  - Complete levels 1..3 -> interval 3,2,2 (floor held). Level saturates at 7 after 7 levels.
//  - Lost low on the terminal-count cycle -> no Scroll, LOST.
//    Start -> LOAD, Level=0, interval back to 4.
//  - Reset low mid-RUN -> all outputs at reset values within the same cycle.
//    With PAUSE_EN, 10-cycle pause delays the next Scroll by exactly 10 cycles.

Source files
------------

// File: rtl/sc_roadfighter_pkg.sv
// sc_roadfighter_pkg
//   Definitions shared by the RoadFighter game-flow blocks: the level
//   sequencer state encoding, the road bus width, the obstacle LFSR seed
//   and the lane-mask constants used by the player FSM and the road bank.
//   No ports; import with "import sc_roadfighter_pkg::*;".
package sc_roadfighter_pkg;

  localparam int         DATAWIDTH_BUS = 8;
  localparam logic [7:0] LFSR_SEED     = 8'hA5;

  typedef enum logic [2:0] {
    ST_LOAD       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_RUN        = 3'd2,
    ST_LEVEL_DONE = 3'd3,
    ST_LOST       = 3'd4
  } sc_seq_state_t;

  localparam logic [DATAWIDTH_BUS-1:0] LANE_NONE = '0;
  localparam logic [DATAWIDTH_BUS-1:0] LANE_ALL  = '1;

  // One-hot mask selecting a single lane of a road row.
  function automatic logic [DATAWIDTH_BUS-1:0] lane_mask(input logic [2:0] lane);
    lane_mask = DATAWIDTH_BUS'(1) << lane;
  endfunction

endpackage

// File: rtl/sc_obstacle_lfsr.sv
// sc_obstacle_lfsr
//   8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that feeds the obstacle pattern.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset, loads SEED
//     step_en  in   advance the register by one step
//     q        out  current LFSR state
module sc_obstacle_lfsr
  import sc_roadfighter_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_en,
  output logic [7:0] q
);

  logic [7:0] q_reg;
  logic [7:0] q_next;
  logic       feedback;

  // Taps for exponents 8,6,5,4 sit at bits 7,5,4,3 of a left-shifting register.
  assign feedback = q_reg[7] ^ q_reg[5] ^ q_reg[4] ^ q_reg[3];

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_shift
      assign q_next[gi] = q_reg[gi-1];
    end
  endgenerate
  assign q_next[0] = feedback;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= SEED;
    end else if (step_en) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/sc_level_sequencer.sv
// sc_level_sequencer
//   Game-flow scheduler for RoadFighter. Issues load / scroll / new-row
//   commands to the road shift-register bank, counts rows to detect the end of
//   a level, shortens the scroll period per level and freezes on collision.
//   Ports:
//     SC_LEVEL_SEQUENCER_CLOCK_50             in   system clock
//     SC_LEVEL_SEQUENCER_RESET_InLow          in   asynchronous active-low reset
//     SC_LEVEL_SEQUENCER_Start_InLow          in   start/restart button (debounced)
//     SC_LEVEL_SEQUENCER_Lost_InLow           in   collision from player FSM, 0 = lost
//     SC_LEVEL_SEQUENCER_Pause_InLow          in   pause, only with SC_LEVEL_SEQUENCER_PAUSE_EN
//     SC_LEVEL_SEQUENCER_Scroll_Out           out  1-cycle pulse: shift road one row down
//     SC_LEVEL_SEQUENCER_LoadRoad_OutLow      out  0 = parallel-load RoadData into bank
//     SC_LEVEL_SEQUENCER_RoadData_Out         out  new top row
//     SC_LEVEL_SEQUENCER_FinishedLevel_OutLow out  1-cycle low pulse at level end
//     SC_LEVEL_SEQUENCER_Level_Out            out  current level
//   Build option: define SC_LEVEL_SEQUENCER_PAUSE_EN to add the pause input.
module sc_level_sequencer
  import sc_roadfighter_pkg::*;
#(
  parameter int         DATAWIDTH_BUS  = sc_roadfighter_pkg::DATAWIDTH_BUS,
  parameter int         PRESC_WIDTH    = 24,
  parameter int         TICK_BASE      = 5_000_000,
  parameter int         TICK_STEP      = 500_000,
  parameter int         TICK_MIN       = 1_000_000,
  parameter int         ROWS_PER_LEVEL = 64,
  parameter int         LEVEL_WIDTH    = 3,
  parameter logic [7:0] LFSR_SEED      = sc_roadfighter_pkg::LFSR_SEED
)
(
  input  logic                     SC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                     SC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic                     SC_LEVEL_SEQUENCER_Start_InLow,
  input  logic                     SC_LEVEL_SEQUENCER_Lost_InLow,
`ifdef SC_LEVEL_SEQUENCER_PAUSE_EN
  input  logic                     SC_LEVEL_SEQUENCER_Pause_InLow,
`endif
  output logic                     SC_LEVEL_SEQUENCER_Scroll_Out,
  output logic                     SC_LEVEL_SEQUENCER_LoadRoad_OutLow,
  output logic [DATAWIDTH_BUS-1:0] SC_LEVEL_SEQUENCER_RoadData_Out,
  output logic                     SC_LEVEL_SEQUENCER_FinishedLevel_OutLow,
  output logic [LEVEL_WIDTH-1:0]   SC_LEVEL_SEQUENCER_Level_Out
);

  // Row counter reaches ROWS_PER_LEVEL (one past the last row) on the final
  // scroll; the level ends on the following cycle, after that scroll pulse.
  localparam int ROW_WIDTH = $clog2(ROWS_PER_LEVEL + 1);
  localparam logic [ROW_WIDTH-1:0]   ROW_END   = ROW_WIDTH'(ROWS_PER_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = '1;
  localparam logic [PRESC_WIDTH-1:0] BASE_P    = PRESC_WIDTH'(TICK_BASE);
  localparam logic [PRESC_WIDTH-1:0] STEP_P    = PRESC_WIDTH'(TICK_STEP);
  localparam logic [PRESC_WIDTH-1:0] MIN_P     = PRESC_WIDTH'(TICK_MIN);
  // Subtract only when the result stays at or above the floor; one extra bit
  // keeps the sum from wrapping.
  localparam logic [PRESC_WIDTH:0]   SUB_OK_P  = (PRESC_WIDTH+1)'(TICK_MIN) + (PRESC_WIDTH+1)'(TICK_STEP);

  sc_seq_state_t            state_reg, state_next;
  logic [PRESC_WIDTH-1:0]   presc_reg, presc_next;
  logic [PRESC_WIDTH-1:0]   period_reg, period_next;
  logic [ROW_WIDTH-1:0]     row_reg, row_next;
  logic [LEVEL_WIDTH-1:0]   level_reg, level_next;
  logic                     scroll_reg, scroll_next;
  logic                     load_road_reg, load_road_next;
  logic [DATAWIDTH_BUS-1:0] road_data_reg, road_data_next;
  logic                     finished_reg, finished_next;

  logic       lfsr_step;
  logic [7:0] lfsr_q;
  logic       run_en;
  logic       terminal_count;

`ifdef SC_LEVEL_SEQUENCER_PAUSE_EN
  assign run_en = SC_LEVEL_SEQUENCER_Pause_InLow;
`else
  assign run_en = 1'b1;
`endif

  assign terminal_count = (presc_reg == period_reg - PRESC_WIDTH'(1));

  sc_obstacle_lfsr #(
    .SEED (LFSR_SEED)
  ) u_obstacle_lfsr (
    .clk     (SC_LEVEL_SEQUENCER_CLOCK_50),
    .rst_n   (SC_LEVEL_SEQUENCER_RESET_InLow),
    .step_en (lfsr_step),
    .q       (lfsr_q)
  );

  always_comb begin
    state_next     = state_reg;
    presc_next     = presc_reg;
    period_next    = period_reg;
    row_next       = row_reg;
    level_next     = level_reg;
    scroll_next    = 1'b0;
    road_data_next = road_data_reg;
    finished_next  = 1'b1;
    lfsr_step      = 1'b0;

    case (state_reg)
      ST_LOAD: begin
        presc_next = '0;
        row_next   = '0;
        state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        presc_next = '0;
        if (!SC_LEVEL_SEQUENCER_Start_InLow) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Collision wins over a coincident terminal count.
        if (!SC_LEVEL_SEQUENCER_Lost_InLow) begin
          state_next = ST_LOST;
        end else if (row_reg == ROW_END) begin
          state_next = ST_LEVEL_DONE;
        end else if (run_en) begin
          if (terminal_count) begin
            presc_next     = '0;
            lfsr_step      = 1'b1;
            scroll_next    = 1'b1;
            // Row is built from the LFSR value before it advances.
            road_data_next = lfsr_q[7] ? DATAWIDTH_BUS'(lane_mask(lfsr_q[2:0])) : '0;
            row_next       = row_reg + ROW_WIDTH'(1);
          end else begin
            presc_next = presc_reg + PRESC_WIDTH'(1);
          end
        end
      end
      ST_LEVEL_DONE: begin
        finished_next = 1'b0;
        if (level_reg != LEVEL_MAX) level_next = level_reg + LEVEL_WIDTH'(1);
        if ({1'b0, period_reg} >= SUB_OK_P) period_next = period_reg - STEP_P;
        else                                period_next = MIN_P;
        row_next   = '0;
        state_next = ST_LOAD;
      end
      ST_LOST: begin
        if (!SC_LEVEL_SEQUENCER_Start_InLow) begin
          level_next  = '0;
          period_next = BASE_P;
          state_next  = ST_LOAD;
        end
      end
      default: state_next = ST_LOAD;
    endcase

    // Load strobe and cleared row line up with the cycle spent in LOAD.
    load_road_next = (state_next != ST_LOAD);
    if (state_next == ST_LOAD) road_data_next = LANE_NONE[DATAWIDTH_BUS-1:0];
  end

  always_ff @(posedge SC_LEVEL_SEQUENCER_CLOCK_50 or negedge SC_LEVEL_SEQUENCER_RESET_InLow) begin
    if (!SC_LEVEL_SEQUENCER_RESET_InLow) begin
      state_reg     <= ST_LOAD;
      presc_reg     <= '0;
      period_reg    <= BASE_P;
      row_reg       <= '0;
      level_reg     <= '0;
      scroll_reg    <= 1'b0;
      load_road_reg <= 1'b0;
      road_data_reg <= '0;
      finished_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      period_reg    <= period_next;
      row_reg       <= row_next;
      level_reg     <= level_next;
      scroll_reg    <= scroll_next;
      load_road_reg <= load_road_next;
      road_data_reg <= road_data_next;
      finished_reg  <= finished_next;
    end
  end

  assign SC_LEVEL_SEQUENCER_Scroll_Out            = scroll_reg;
  assign SC_LEVEL_SEQUENCER_LoadRoad_OutLow       = load_road_reg;
  assign SC_LEVEL_SEQUENCER_RoadData_Out          = road_data_reg;
  assign SC_LEVEL_SEQUENCER_FinishedLevel_OutLow  = finished_reg;
  assign SC_LEVEL_SEQUENCER_Level_Out             = level_reg;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// tb_sc_level_sequencer
//   Directed/randomized bench for sc_level_sequencer with small timing
//   parameters. Expected intervals, rows and levels come from a reference
//   model built from the game rules.
module tb_sc_level_sequencer;

  localparam int TB_BASE = 4;
  localparam int TB_STEP = 1;
  localparam int TB_MIN  = 2;
  localparam int TB_ROWS = 3;
  localparam int TB_LW   = 3;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start_n = 1'b1;
  logic lost_n  = 1'b1;
`ifdef SC_LEVEL_SEQUENCER_PAUSE_EN
  logic pause_n = 1'b1;
`endif

  logic             scroll;
  logic             load_n;
  logic [7:0]       road;
  logic             fin_n;
  logic [TB_LW-1:0] level;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int         m_done;   // levels completed since last (re)start from level 0
  logic [7:0] m_lfsr;

  always #5 clk = ~clk;

  sc_level_sequencer #(
    .DATAWIDTH_BUS  (8),
    .PRESC_WIDTH    (24),
    .TICK_BASE      (TB_BASE),
    .TICK_STEP      (TB_STEP),
    .TICK_MIN       (TB_MIN),
    .ROWS_PER_LEVEL (TB_ROWS),
    .LEVEL_WIDTH    (TB_LW),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .SC_LEVEL_SEQUENCER_CLOCK_50             (clk),
    .SC_LEVEL_SEQUENCER_RESET_InLow          (rst_n),
    .SC_LEVEL_SEQUENCER_Start_InLow          (start_n),
    .SC_LEVEL_SEQUENCER_Lost_InLow           (lost_n),
`ifdef SC_LEVEL_SEQUENCER_PAUSE_EN
    .SC_LEVEL_SEQUENCER_Pause_InLow          (pause_n),
`endif
    .SC_LEVEL_SEQUENCER_Scroll_Out           (scroll),
    .SC_LEVEL_SEQUENCER_LoadRoad_OutLow      (load_n),
    .SC_LEVEL_SEQUENCER_RoadData_Out         (road),
    .SC_LEVEL_SEQUENCER_FinishedLevel_OutLow (fin_n),
    .SC_LEVEL_SEQUENCER_Level_Out            (level)
  );

  function automatic int exp_period();
    int p;
    p = TB_BASE - TB_STEP * m_done;
    return (p < TB_MIN) ? TB_MIN : p;
  endfunction

  function automatic int exp_level();
    return (m_done > 7) ? 7 : m_done;
  endfunction

  function automatic logic [7:0] exp_row(input logic [7:0] s);
    logic [7:0] one;
    one = 8'd1;
    return s[7] ? (one << s[2:0]) : 8'd0;
  endfunction

  // Polynomial x^8+x^6+x^5+x^4+1: parity of bits 7,5,4,3 shifts in at bit 0.
  function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles until the next Scroll pulse, -1 if none within the budget.
  task automatic wait_scroll(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (scroll !== 1'b1 && n < 100);
    if (scroll !== 1'b1) n = -1;
  endtask

  task automatic press_start(input int idle);
    int sc;
    sc = 0;
    repeat (idle) begin
      step();
      if (scroll === 1'b1) sc++;
    end
    check("idle_no_scroll", sc, 0);
    start_n = 1'b0;
    step();
    start_n = 1'b1;
  endtask

  task automatic scroll_once(input string tag);
    int n;
    wait_scroll(n);
    check({tag, "_interval"}, n, exp_period());
    check({tag, "_road"}, road, exp_row(m_lfsr));
    $display("[TB] scroll level=%0d interval=%0d road=%02h", level, n, road);
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  task automatic play_level();
    for (int r = 0; r < TB_ROWS; r++) scroll_once("lvl");
    step();
    check("done_scroll_low", scroll, 0);
    check("done_fin_high", fin_n, 1);
    step();
    m_done++;
    check("fin_pulse", fin_n, 0);
    check("fin_no_scroll", scroll, 0);
    check("fin_load", load_n, 0);
    check("fin_road_clear", road, 0);
    check("fin_level", level, exp_level());
    step();
    check("fin_release", fin_n, 1);
    check("load_release", load_n, 1);
    $display("[TB] level done, level=%0d", level);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int n;
    int k;

    // Reset state
    repeat (3) step();
    check("rst_scroll", scroll, 0);
    check("rst_load", load_n, 0);
    check("rst_road", road, 0);
    check("rst_fin", fin_n, 1);
    check("rst_level", level, 0);

    rst_n = 1'b1;
    #1;
    check("load_cycle_load", load_n, 0);
    check("load_cycle_road", road, 0);
    step();
    check("wait_start_load", load_n, 1);
    sc = 0;
    repeat (20) begin
      step();
      if (scroll === 1'b1) sc++;
    end
    check("no_scroll_20", sc, 0);
    $display("[TB] reset/load sequence checked");

    m_done = 0;
    m_lfsr = 8'hA5;

    // Nine levels: intervals 4,3,2,2..., level saturates at 7
    for (int lv = 0; lv < 9; lv++) begin
      press_start(int'($urandom_range(0, 3)));
      play_level();
    end

    // Collision exactly on the terminal-count cycle
    press_start(int'($urandom_range(0, 3)));
    k = int'($urandom_range(0, 1));
    for (int i = 0; i < k; i++) scroll_once("prelost");
    repeat (exp_period() - 1) step();
    lost_n = 1'b0;
    step();
    lost_n = 1'b1;
    check("lost_no_scroll", scroll, 0);
    sc = 0;
    repeat (10) begin
      step();
      if (scroll === 1'b1) sc++;
    end
    check("lost_frozen", sc, 0);
    check("lost_level_held", level, exp_level());
    $display("[TB] lost at terminal count, level=%0d", level);

    start_n = 1'b0;
    step();
    start_n = 1'b1;
    m_done = 0;
    check("restart_load", load_n, 0);
    check("restart_level", level, 0);
    check("restart_fin", fin_n, 1);
    step();
    check("restart_wait", load_n, 1);
    press_start(int'($urandom_range(0, 3)));
    scroll_once("restart");

`ifdef SC_LEVEL_SEQUENCER_PAUSE_EN
    // 10-cycle pause delays the next scroll by exactly 10 cycles
    step();
    pause_n = 1'b0;
    repeat (10) step();
    pause_n = 1'b1;
    wait_scroll(n);
    check("pause_interval", (n < 0) ? n : n + 11, exp_period() + 10);
    check("pause_road", road, exp_row(m_lfsr));
    $display("[TB] pause scroll interval=%0d", n + 11);
    m_lfsr = lfsr_adv(m_lfsr);
`endif

    // Asynchronous reset while the scroll pulse is high
    check("pre_reset_scroll", scroll, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_scroll", scroll, 0);
    check("async_rst_load", load_n, 0);
    check("async_rst_road", road, 0);
    check("async_rst_fin", fin_n, 1);
    check("async_rst_level", level, 0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    m_done = 0;
    m_lfsr = 8'hA5;
    check("post_rst_load", load_n, 0);
    step();
    check("post_rst_wait", load_n, 1);
    press_start(int'($urandom_range(0, 3)));
    scroll_once("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
